// File: rtl/ifetch_response.sv
// Instruction-fetch response stage: pairs AXI4-Lite R-channel words with the PCs of
// outstanding requests, drops responses made stale by a flush, and registers {instr, pc, fault} for decode.
`timescale 1ns/1ps
module ifetch_response #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_ar_fire,
  input  logic [XLEN-1:0] i_ar_addr,
  output logic            o_ar_stall,
  input  logic            i_flush,
  input  logic            i_im_rvalid,
  output logic            o_im_rready,
  input  logic [XLEN-1:0] i_im_rdata,
  input  logic [1:0]      i_im_rresp,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic            o_if_fault,
  output logic            o_proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pcq [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_q_count;
  logic [CW-1:0]   r_drop_cnt;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;
  logic            r_if_fault;
  logic            r_proto_err;

  logic [CW:0]     w_total;
  logic            w_q_nz;
  logic            w_drop_nz;
  logic            w_enq;
  logic            w_r_fire;
  logic            w_drop;
  logic            w_pop;
  logic [XLEN-1:0] w_head;
  logic            w_fault;
  logic [CW-1:0]   w_flush_drop;

  // Stall counts stale (drop) responses too: they still occupy memory-side slots.
  assign w_total      = {1'b0, r_q_count} + {1'b0, r_drop_cnt};
  assign o_ar_stall   = (w_total == (CW+1)'(DEPTH));
  assign w_q_nz       = (r_q_count != '0);
  assign w_drop_nz    = (r_drop_cnt != '0);
  assign w_enq        = i_ar_fire & ~o_ar_stall;
  assign o_im_rready  = w_drop_nz | (w_q_nz & (~r_if_valid | i_if_ready));
  assign w_r_fire     = i_im_rvalid & o_im_rready;
  assign w_drop       = w_r_fire & w_drop_nz;
  assign w_pop        = w_r_fire & ~w_drop_nz;
  assign w_head       = r_pcq[r_rptr];
  assign w_fault      = (i_im_rresp != 2'b00) | (w_head[1:0] != 2'b00);
  assign w_flush_drop = r_drop_cnt + r_q_count - {{(CW-1){1'b0}}, w_r_fire};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_pcq[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_q_count   <= '0;
      r_drop_cnt  <= '0;
      r_if_valid  <= 1'b0;
      r_if_instr  <= '0;
      r_if_pc     <= '0;
      r_if_fault  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (i_im_rvalid & ~w_q_nz & ~w_drop_nz) r_proto_err <= 1'b1;

      if (i_flush) begin
        // A request issued in the flush cycle starts the new stream at slot 0.
        r_drop_cnt <= w_flush_drop;
        r_rptr     <= '0;
        r_if_valid <= 1'b0;
        if (w_enq) begin
          r_pcq[0]  <= i_ar_addr;
          r_wptr    <= PW'(1);
          r_q_count <= CW'(1);
        end else begin
          r_wptr    <= '0;
          r_q_count <= '0;
        end
      end else begin
        if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_enq) begin
          r_pcq[r_wptr] <= i_ar_addr;
          r_wptr        <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        case ({w_enq, w_pop})
          2'b10:   r_q_count <= r_q_count + CW'(1);
          2'b01:   r_q_count <= r_q_count - CW'(1);
          default: r_q_count <= r_q_count;
        endcase

        if (w_pop) begin
          r_if_valid <= 1'b1;
          r_if_instr <= w_fault ? '0 : i_im_rdata;
          r_if_pc    <= w_head;
          r_if_fault <= w_fault;
        end else if (r_if_valid & i_if_ready) begin
          r_if_valid <= 1'b0;
        end
      end
    end
  end

  assign o_if_valid  = r_if_valid;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc     = r_if_pc;
  assign o_if_fault  = r_if_fault;
  assign o_proto_err = r_proto_err;

  // Upstream must never complete a request while we report full.
  ar_fire_when_stalled: assert property (@(posedge clk) disable iff (!rstn) !(i_ar_fire && o_ar_stall));

endmodule

// File: tb/tb_ifetch_response.sv
// Randomized + directed bench for ifetch_response: memory responder, queue-level reference model, scoreboard monitor.
`timescale 1ns/1ps
module tb_ifetch_response;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        i_ar_fire;
  logic [31:0] i_ar_addr;
  logic        o_ar_stall;
  logic        i_flush;
  logic        i_im_rvalid;
  logic        o_im_rready;
  logic [31:0] i_im_rdata;
  logic [1:0]  i_im_rresp;
  logic        o_if_valid;
  logic        i_if_ready;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        o_if_fault;
  logic        o_proto_err;

  ifetch_response #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .i_ar_fire(i_ar_fire), .i_ar_addr(i_ar_addr), .o_ar_stall(o_ar_stall),
    .i_flush(i_flush),
    .i_im_rvalid(i_im_rvalid), .o_im_rready(o_im_rready),
    .i_im_rdata(i_im_rdata), .i_im_rresp(i_im_rresp),
    .o_if_valid(o_if_valid), .i_if_ready(i_if_ready),
    .o_if_instr(o_if_instr), .o_if_pc(o_if_pc), .o_if_fault(o_if_fault),
    .o_proto_err(o_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard of instructions decode should see, oldest first.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;
  exp_t expq[$];

  // Reference model: live PCs in order, count of stale responses still owed.
  logic [31:0] m_pcq[$];
  int          m_drop = 0;
  bit          m_valid = 0;
  bit          m_proto = 0;
  bit          m_full, m_rdy, m_fire, m_arok;
  exp_t        m_e;
  logic [31:0] m_pc;

  always begin
    @(negedge clk); #2;
    m_full = (m_pcq.size() + m_drop == DEPTH);
    m_rdy  = (m_drop != 0) || (m_pcq.size() != 0 && (!m_valid || i_if_ready));
    chk("ar_stall", {63'd0, o_ar_stall}, {63'd0, m_full});
    chk("im_rready", {63'd0, o_im_rready}, {63'd0, m_rdy});
    chk("proto_err", {63'd0, o_proto_err}, {63'd0, m_proto});
    if (!rstn) begin
      m_pcq.delete(); m_drop = 0; m_valid = 0; m_proto = 0; expq.delete();
    end else begin
      m_fire = i_im_rvalid && m_rdy;
      m_arok = i_ar_fire && !m_full;
      if (i_im_rvalid && m_pcq.size() == 0 && m_drop == 0) m_proto = 1;
      if (i_flush) begin
        m_drop = m_drop + m_pcq.size() - (m_fire ? 1 : 0);
        m_pcq.delete(); m_valid = 0; expq.delete();
        if (m_arok) m_pcq.push_back(i_ar_addr);
      end else begin
        if (m_valid && i_if_ready) m_valid = 0;
        if (m_fire) begin
          if (m_drop > 0) m_drop--;
          else begin
            m_pc = m_pcq.pop_front();
            m_e.pc    = m_pc;
            m_e.fault = (i_im_rresp != 2'b00) || (m_pc[1:0] != 2'b00);
            m_e.instr = m_e.fault ? 32'd0 : i_im_rdata;
            expq.push_back(m_e);
            m_valid = 1;
          end
        end
        if (m_arok) m_pcq.push_back(i_ar_addr);
      end
    end
  end

  // Monitor: compares whatever decode is shown against the scoreboard head.
  always begin
    @(negedge clk); #1;
    chk("if_valid", {63'd0, o_if_valid}, {63'd0, expq.size() != 0});
    if (o_if_valid && expq.size() != 0) begin
      chk("if_instr", {32'd0, o_if_instr}, {32'd0, expq[0].instr});
      chk("if_pc", {32'd0, o_if_pc}, {32'd0, expq[0].pc});
      chk("if_fault", {63'd0, o_if_fault}, {63'd0, expq[0].fault});
      if (i_if_ready) expq.delete(0);
    end
  end

  // Memory responder state (answers every accepted request in order, including stale ones).
  logic [31:0] mem_q[$];
  bit          last_rst = 1, last_fire = 0, last_ar = 0;
  logic [31:0] last_addr = 0;
  bit          rst_req = 1;
  bit          use_fixed = 0;
  logic [31:0] fixed_data = 0;
  int          err_pct = 0;

  task automatic cyc(input bit ar, input logic [31:0] addr, input bit fl, input bit rdy,
                     input int rate, input bit bogus);
    @(negedge clk);
    rstn = !rst_req;
    if (last_rst) mem_q.delete();
    else begin
      if (last_fire && mem_q.size() != 0) mem_q.delete(0);
      if (last_ar) mem_q.push_back(last_addr);
    end
    if (bogus) begin
      i_im_rvalid = 1'b1; i_im_rdata = $urandom; i_im_rresp = 2'b00;
    end else if (i_im_rvalid && !last_fire && !last_rst && mem_q.size() != 0) begin
      i_im_rvalid = 1'b1;
    end else if (mem_q.size() != 0 && int'($urandom_range(99)) < rate) begin
      i_im_rvalid = 1'b1;
      i_im_rdata  = use_fixed ? fixed_data : $urandom;
      i_im_rresp  = (int'($urandom_range(99)) < err_pct) ? 2'b10 : 2'b00;
    end else begin
      i_im_rvalid = 1'b0;
    end
    i_ar_fire  = ar && !o_ar_stall && !rst_req;
    i_ar_addr  = addr;
    i_flush    = fl;
    i_if_ready = rdy;
    #2;
    last_rst  = !rstn;
    last_fire = i_im_rvalid && o_im_rready;
    last_ar   = i_ar_fire && !o_ar_stall;
    last_addr = i_ar_addr;
  endtask

  task automatic wait_valid(input string nm);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc(0, 0, 0, 1, 100, 0);
      if (o_if_valid) got = 1;
    end
    chk({nm, "_seen"}, {63'd0, got}, 64'd1);
  endtask

  task automatic drain();
    repeat (30) cyc(0, 0, 0, 1, 100, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] pcs[$];
    int          nv;
    logic [31:0] lpc;
    rstn = 1'b0; i_ar_fire = 0; i_ar_addr = 0; i_flush = 0;
    i_im_rvalid = 0; i_im_rdata = 0; i_im_rresp = 0; i_if_ready = 0;

    // Reset with rvalid asserted
    rst_req = 1;
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("rst_valid", {63'd0, o_if_valid}, 64'd0);
    chk("rst_instr", {32'd0, o_if_instr}, 64'd0);
    chk("rst_pc", {32'd0, o_if_pc}, 64'd0);
    chk("rst_fault", {63'd0, o_if_fault}, 64'd0);
    chk("rst_proto", {63'd0, o_proto_err}, 64'd0);
    chk("rst_stall", {63'd0, o_ar_stall}, 64'd0);
    chk("rst_rready", {63'd0, o_im_rready}, 64'd0);
    rst_req = 0;
    cyc(0, 0, 0, 0, 0, 0);

    // Single fetch
    use_fixed = 1; fixed_data = 32'h0050_0093;
    cyc(1, 32'h100, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 100, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("single_valid", {63'd0, o_if_valid}, 64'd1);
    chk("single_pc", {32'd0, o_if_pc}, 64'h100);
    chk("single_instr", {32'd0, o_if_instr}, 64'h0050_0093);
    chk("single_fault", {63'd0, o_if_fault}, 64'd0);
    use_fixed = 0;
    drain();

    // Backpressure / full
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 100, 0);
    chk("bp_stall", {63'd0, o_ar_stall}, 64'd1);
    cyc(0, 0, 0, 0, 100, 0);
    chk("bp_rready_held", {63'd0, o_im_rready}, 64'd0);
    cyc(0, 0, 0, 0, 100, 0);
    chk("bp_rready_held2", {63'd0, o_im_rready}, 64'd0);
    chk("bp_hold_pc", {32'd0, o_if_pc}, 64'h0);
    for (int k = 0; k < 20 && pcs.size() < 4; k++) begin
      cyc(0, 0, 0, 1, 100, 0);
      if (o_if_valid) pcs.push_back(o_if_pc);
    end
    chk("bp_count", 64'(pcs.size()), 64'd4);
    for (int i = 0; i < pcs.size(); i++) chk("bp_order", {32'd0, pcs[i]}, 64'(i * 4));
    drain();

    // Flush with a coincident new request
    cyc(1, 32'h10, 0, 1, 0, 0);
    cyc(1, 32'h14, 0, 1, 0, 0);
    cyc(1, 32'h18, 0, 1, 0, 0);
    cyc(1, 32'h200, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("flush_stall_full", {63'd0, o_ar_stall}, 64'd1);
    nv = 0; lpc = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 1, 100, 0);
      if (o_if_valid) begin nv++; lpc = o_if_pc; end
    end
    chk("flush_delivered", 64'(nv), 64'd1);
    chk("flush_pc", {32'd0, lpc}, 64'h200);

    // Flush with a response firing in the same cycle
    cyc(1, 32'h300, 0, 1, 0, 0);
    cyc(1, 32'h304, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 100, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("flr_valid", {63'd0, o_if_valid}, 64'd0);
    chk("flr_rready_drop", {63'd0, o_im_rready}, 64'd1);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 1, 100, 0);
      if (o_if_valid) nv++;
    end
    chk("flr_none", 64'(nv), 64'd0);
    chk("flr_rready_idle", {63'd0, o_im_rready}, 64'd0);
    chk("flr_stall_idle", {63'd0, o_ar_stall}, 64'd0);

    // Randomized traffic with one mid-run reset
    err_pct = 10;
    for (int n = 0; n < 3000; n++) begin
      rst_req = (n >= 1500 && n < 1502);
      a = $urandom & 32'hffff_fffc;
      if ($urandom_range(9) == 0) a[1:0] = 2'($urandom_range(3));
      cyc($urandom_range(1) == 1, a, $urandom_range(19) == 0, $urandom_range(9) < 7, 60, 0);
    end
    rst_req = 0;
    err_pct = 0;
    drain();

    // Bus-error fault
    err_pct = 100;
    cyc(1, 32'h40, 0, 1, 0, 0);
    wait_valid("berr");
    chk("berr_fault", {63'd0, o_if_fault}, 64'd1);
    chk("berr_instr", {32'd0, o_if_instr}, 64'd0);
    chk("berr_pc", {32'd0, o_if_pc}, 64'h40);
    err_pct = 0;
    drain();

    // Misaligned PC fault
    cyc(1, 32'h42, 0, 1, 0, 0);
    wait_valid("misal");
    chk("misal_fault", {63'd0, o_if_fault}, 64'd1);
    chk("misal_instr", {32'd0, o_if_instr}, 64'd0);
    chk("misal_pc", {32'd0, o_if_pc}, 64'h42);
    drain();

    // Response with nothing outstanding
    cyc(0, 0, 0, 1, 0, 1);
    chk("proto_rready", {63'd0, o_im_rready}, 64'd0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("proto_set", {63'd0, o_proto_err}, 64'd1);
    repeat (5) cyc(0, 0, 0, 1, 0, 0);
    chk("proto_sticky", {63'd0, o_proto_err}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_response.md
Name: ifetch_response

Overview:
- Instruction-fetch response stage, directly downstream of the PC/address-issue stage.
- Records the address of every accepted instruction-memory read request, in order.
- Consumes the instruction-memory AXI4-Lite R channel and pairs each instruction word with its PC.
- Presents {instr, pc, fault} to decode over a valid/ready interface. Discards in-flight responses on branch/jump flush.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, max outstanding read requests (power of 2, >=2)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
i_ar_fire  input  1  AR handshake completed this cycle (arvalid & arready at memory side)
i_ar_addr  input  XLEN  address of that request
o_ar_stall  output  1  upstream must not issue a new request
i_flush  input  1  redirect; all older fetches are stale
i_im_rvalid  input  1  R channel valid
o_im_rready  output  1  R channel ready
i_im_rdata  input  XLEN  instruction word
i_im_rresp  input  2  AXI response (00 = OKAY)
o_if_valid  output  1  instruction valid to decode
i_if_ready  input  1  decode accepts
o_if_instr  output  XLEN  instruction
o_if_pc  output  XLEN  PC of instruction
o_if_fault  output  1  fetch fault (bus error or misaligned PC)
o_proto_err  output  1  sticky: response with nothing outstanding

Behaviour:
- Reset is synchronous, active-low, on rstn, clocked by clk. All state clears.
- Reset values: o_if_valid=0, o_if_instr=0, o_if_pc=0, o_if_fault=0, o_proto_err=0, o_ar_stall=0. PC queue is empty; q_count=0, drop_cnt=0.
- Counters q_count and drop_cnt are $clog2(DEPTH+1) bits wide.
- PC queue: circular FIFO of DEPTH entries.
  - Write on i_ar_fire.
  - Pointers wrap modulo DEPTH.
  - q_count counts live entries.
- o_ar_stall = (q_count + drop_cnt == DEPTH), combinational.
  - i_ar_fire while stalled is a protocol violation; the assertion fires and the request is ignored.
- r_fire = i_im_rvalid & o_im_rready.
- o_im_rready = (drop_cnt != 0) | (q_count != 0 & (!o_if_valid | i_if_ready)).
- r_fire consumption order: drop_cnt first, then the queue.
  - If drop_cnt != 0: decrement drop_cnt and discard the data.
  - Otherwise: pop the queue head and load the output register. Next cycle o_if_valid=1, o_if_instr=rdata, o_if_pc=head.
  - Latency is 1 cycle from r_fire to o_if_valid.
  - Throughput is 1 instruction/cycle when i_if_ready=1.
- Fault: o_if_fault=1 if rresp!=00 or head[1:0]!=00; o_if_instr is then forced to 0. The PC is still reported.
- Output register hold: o_if_valid stays 1 with stable data until i_if_ready.
  - It clears on an accept with no new r_fire.
  - Accept and r_fire in the same cycle reload it.
- Rvalid with q_count=0 and drop_cnt=0:
  - o_im_rready=0, so the R channel stalls.
  - o_proto_err sets and is held until reset.
- Flush (i_flush=1), same cycle:
  - drop_cnt <= drop_cnt + q_count - (r_fire ? 1 : 0).
  - Queue is cleared (pointers reset, q_count=0).
  - o_if_valid <= 0, whether or not i_if_ready.
  - A response arriving this cycle is discarded.
- Flush coincident with i_ar_fire: that request belongs to the new stream. It is enqueued after the clear, so q_count=1 next cycle.
- Simultaneous enqueue and dequeue (no flush): q_count unchanged.
- Back-to-back flushes accumulate into drop_cnt. The total q_count + drop_cnt never exceeds DEPTH.
- rstn low mid-operation: all counts and queue cleared next edge. Outstanding bus responses are not tracked; memory is reset by the same rstn.

Test Plan:
- Reset:
  - Stimulus: hold rstn=0 for 3 cycles with i_im_rvalid=1.
  - Required: all outputs 0, o_im_rready=0.
- Single fetch:
  - Stimulus: ar_fire addr 0x100; R 0x00500093 two cycles later.
  - Required: o_if_valid=1 the cycle after r_fire, with pc=0x100, instr=0x00500093, fault=0.
- Backpressure/full:
  - Stimulus: issue 4 requests (0x0,0x4,0x8,0xC) with i_if_ready=0.
  - Required: o_ar_stall=1 after the 4th.
  - Required: only 1 response is accepted; rready=0 after it until decode accepts.
  - Required: on release, in-order pcs 0x0..0xC.
- Flush:
  - Stimulus: 3 outstanding, then i_flush together with ar_fire 0x200; then 4 responses.
  - Required: first 3 discarded; 4th delivered with pc=0x200.
  - Required: o_ar_stall=1 while 3 drop + 1 live are in flight (full).
- Flush with coincident r_fire:
  - Stimulus: 2 outstanding, response arrives in the flush cycle.
  - Required: drop_cnt=1; no output valid.
- Faults:
  - Stimulus: rresp=10 on pc 0x40.
  - Required: fault=1, instr=0, pc=0x40.
  - Stimulus: ar addr 0x42.
  - Required: fault=1.
  - Stimulus: rvalid with nothing outstanding.
  - Required: o_proto_err=1, sticky.
